mem2apb: RTL and testbench
==========================

# mem2apb

Bridge between the CPU's valid/ready data-memory port and the APB master port that feeds `apbbus`. Converts each CPU load or store into one APB3/APB4 transfer (SETUP then ACCESS with wait states) and returns the read data as a single-cycle `mem_ready` response. A programmable timeout terminates transfers to slaves that never assert `pready`.

## Interface

Parameters:
- `TIMEOUT`, default 255: maximum number of ACCESS cycles without `pready` before the bridge aborts. 0 disables the timeout. Counter width is `$clog2(TIMEOUT+1)`, minimum 1.
- `ERR_DATA`, default 32'hdeadbeef: value returned on `mem_rdata` after a timeout.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`, input, 1: clock.
  - `rst`, input, 1: asynchronous active-high reset.
- CPU side:
  - `mem_valid`, input, 1: request valid.
  - `mem_addr`, input, 32: byte address.
  - `mem_wdata`, input, 32: write data.
  - `mem_wstrb`, input, 4: byte enables. 0 means read; non-zero means write.
  - `mem_ready`, output, 1: one-cycle completion pulse.
  - `mem_rdata`, output, 32: read data, valid while `mem_ready` is high.
- APB master side, connecting to the `up_*` ports of `apbbus`:
  - `psel`, output, 1.
  - `penable`, output, 1.
  - `pwrite`, output, 1.
  - `paddr`, output, 32.
  - `pwdata`, output, 32.
  - `pstrb`, output, 4.
  - `pready`, input, 1.
  - `prdata`, input, 32.
- Status:
  - `timeout_err`, output, 1: one-cycle pulse, coincident with the `mem_ready` of an aborted transfer.

## Operation

- State machine: IDLE, SETUP, ACCESS, RESP.
- **IDLE**, when `mem_valid`=1 at a clock edge:
  - Latch `paddr={mem_addr[31:2],2'b00}`, `pwdata=mem_wdata`, `pwrite=|mem_wstrb`, `pstrb=mem_wstrb` (`pstrb`=0 for reads).
  - Go to SETUP.
- **SETUP**: `psel`=1, `penable`=0. Clear the timeout counter. Go unconditionally to ACCESS.
- **ACCESS**: `psel`=1, `penable`=1.
  - If `pready`=1: capture `prdata` into `mem_rdata` (reads only; writes leave `mem_rdata` unchanged) and go to RESP.
  - Else, if `TIMEOUT`≠0 and the counter equals `TIMEOUT`-1: load `ERR_DATA` into `mem_rdata`, set a pending-error flag, and go to RESP.
  - Else: increment the counter and stay in ACCESS.
- **RESP**: `psel`=0, `penable`=0. `mem_ready`=1 for exactly this cycle. `timeout_err`=pending flag, then clear the flag. Go to IDLE.
  - `mem_valid` is not sampled in RESP. The master deasserts it or presents a new request, which is taken in the following IDLE cycle.
- `paddr`, `pwdata`, `pwrite` and `pstrb` hold their latched values from SETUP through RESP, and stay stable until the next accepted request (APB stability rule).
- A `mem_valid` drop or change after acceptance is ignored. The APB transfer always completes and `mem_ready` still pulses.
- Writes with `pready` and a timeout both pending in the same ACCESS cycle: `pready` wins, no error.
- The bridge does no address decoding. Out-of-range addresses are handled by `apbbus`, which returns 32'hdeadbeef with `pready`=1.

## Timing

- Reset values (asynchronous, apply immediately, including mid-transfer): state IDLE; `psel`, `penable`, `pwrite`, `mem_ready`, `timeout_err` = 0; `paddr`, `pwdata`, `mem_rdata` = 0; `pstrb`=0; counter 0; pending flag 0.
  - Reset during ACCESS drops `psel` and `penable` in the same cycle. No `mem_ready` is generated.
- Latency, with the request-accepted edge as cycle 0:
  - Cycle 1: SETUP.
  - Cycle 2: first ACCESS.
  - Cycle 3+W: RESP, where W is the number of wait cycles with `pready`=0.
  - Zero-wait transfer: `mem_ready` in cycle 3.
- Throughput: one transfer per 4 cycles at zero wait states, since IDLE is always visited once between transfers.
- Timeout: with no `pready`, RESP occurs in cycle 2+`TIMEOUT`, i.e. exactly `TIMEOUT` ACCESS cycles.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `pready` or `prdata` to any output.

## Test plan

- **Zero-wait read:** read `mem_addr`=0x0001_0007, slave `pready`=1, `prdata`=0x1234_5678. Required: `paddr`=0x0001_0004, `psel` high in cycles 1-2, `penable` high in cycle 2 only, `mem_ready`=1 in cycle 3 with `mem_rdata`=0x1234_5678, `timeout_err`=0.
- **Byte write with waits:** write `mem_wstrb`=4'b0010, `mem_wdata`=0xAABBCCDD, slave inserts 3 wait cycles. Required: `pwrite`=1, `pstrb`=0010, `pwdata` stable throughout, `mem_ready` in cycle 6, `mem_rdata` unchanged.
- **Timeout:** `TIMEOUT`=4, slave never ready. Required: 4 ACCESS cycles, `mem_ready` and `timeout_err` both pulse in cycle 6, `mem_rdata`=0xDEADBEEF.
- **`pready` on the last allowed cycle:** `TIMEOUT`=4, `pready`=1 on the 4th ACCESS cycle. Required: normal completion with `prdata` returned and `timeout_err`=0.
- **Back-to-back:** `mem_valid` held high across two requests. Required: second SETUP occurs 2 cycles after the first `mem_ready`, and the two `mem_ready` pulses are 4 cycles apart.
- **Reset mid-ACCESS:** assert `rst` during a wait state. Required: `psel` and `penable` drop immediately, all outputs return to reset values, no `mem_ready`, and the next request after reset completes normally.

Source files
------------

// File: rtl/mem2apb.sv
// mem2apb: turns each CPU valid/ready load or store into one APB SETUP/ACCESS transfer.
// Stalled transfers are cut off after TIMEOUT ACCESS cycles (0 disables the timeout).
module mem2apb #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic [3:0]  pstrb,
    input  logic        pready,
    input  logic [31:0] prdata,
    output logic        timeout_err
);
    localparam int unsigned CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      paddr_n, pwdata_n, rdata_n;
    logic [3:0]       pstrb_n;
    logic             pwrite_n, psel_n, penable_n, ready_n, terr_n;

    // Next-state and next-register values; every output flop is loaded from here.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        paddr_n   = paddr;
        pwdata_n  = pwdata;
        pwrite_n  = pwrite;
        pstrb_n   = pstrb;
        rdata_n   = mem_rdata;
        terr_n    = 1'b0;
        psel_n    = 1'b0;
        penable_n = 1'b0;
        ready_n   = 1'b0;

        case (state)
            IDLE: begin
                if (mem_valid) begin
                    // Word-align the address; the byte offset is carried by pstrb.
                    paddr_n  = mem_addr & 32'hffff_fffc;
                    pwdata_n = mem_wdata;
                    pwrite_n = |mem_wstrb;
                    pstrb_n  = mem_wstrb;
                    state_n  = SETUP;
                end
            end
            SETUP: begin
                cnt_n   = '0;
                state_n = ACCESS;
            end
            ACCESS: begin
                // pready takes priority over a timeout expiring in the same cycle.
                if (pready) begin
                    if (!pwrite) begin
                        rdata_n = prdata;
                    end
                    state_n = RESP;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    rdata_n = ERR_DATA;
                    terr_n  = 1'b1;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        psel_n    = (state_n == SETUP) || (state_n == ACCESS);
        penable_n = (state_n == ACCESS);
        ready_n   = (state_n == RESP);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            pstrb       <= '0;
            mem_rdata   <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            mem_ready   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            paddr       <= paddr_n;
            pwdata      <= pwdata_n;
            pwrite      <= pwrite_n;
            pstrb       <= pstrb_n;
            mem_rdata   <= rdata_n;
            psel        <= psel_n;
            penable     <= penable_n;
            mem_ready   <= ready_n;
            timeout_err <= terr_n;
        end
    end

endmodule

// File: tb/tb_mem2apb.sv
// tb_mem2apb: random and directed CPU requests against a transaction-level model of
// the bridge, with a reactive APB slave that inserts a chosen number of wait states.
module tb_mem2apb;
    localparam int unsigned TO  = 4;
    localparam logic [31:0] ERR = 32'hdeadbeef;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Stimulus intent for the request currently presented on the CPU port.
    int          cur_wait   = 0;
    logic [31:0] cur_prdata = '0;

    // Transaction-level model: accept edge, number of ACCESS cycles, error outcome.
    int          cyc = 0, t0 = 0, m_acc = 0, m_wait = 0, n_acc = 0, acc_n = 0;
    bit          have = 1'b0, m_err = 1'b0;
    logic [31:0] m_prdata = '0, e_paddr = '0, e_pwdata = '0, e_rdata = '0;
    logic        e_pwrite = 1'b0;
    logic [3:0]  e_pstrb = '0;

    mem2apb #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model update: a request is taken once the previous one has had its response
    // cycle plus one idle cycle; the response lands ACCESS-count+1 edges after accept.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            have = 1'b0; e_paddr = '0; e_pwdata = '0; e_pwrite = 1'b0;
            e_pstrb = '0; e_rdata = '0;
        end else begin
            if (have && (cyc - t0 == m_acc + 1))
                e_rdata = m_err ? ERR : (e_pwrite ? e_rdata : m_prdata);
            if (mem_valid && (!have || (cyc - t0 >= m_acc + 3))) begin
                t0 = cyc; have = 1'b1;
                e_paddr  = {mem_addr[31:2], 2'b00};
                e_pwdata = mem_wdata;
                e_pwrite = (mem_wstrb != 4'd0);
                e_pstrb  = mem_wstrb;
                m_wait   = cur_wait;
                m_prdata = cur_prdata;
                if (m_wait + 1 > int'(TO)) begin
                    m_acc = int'(TO); m_err = 1'b1;
                end else begin
                    m_acc = m_wait + 1; m_err = 1'b0;
                end
                n_acc++;
            end
        end
    end

    // APB slave: ready on access number m_wait+1, garbage data otherwise,
    // and random pready noise during SETUP that the bridge must ignore.
    always @(negedge clk) begin
        if (psel && penable) acc_n = acc_n + 1;
        else acc_n = 0;
        if (psel && penable && (acc_n == m_wait + 1)) begin
            pready = 1'b1;
            prdata = m_prdata;
        end else begin
            pready = psel & ~penable & 1'($urandom_range(0, 1));
            prdata = $urandom;
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        int k;
        bit ep, ee, er;
        k  = cyc - t0;
        ep = have && (k <= m_acc);
        ee = have && (k >= 1) && (k <= m_acc);
        er = have && (k == m_acc + 1);
        check("psel", 32'(psel), 32'(ep));
        check("penable", 32'(penable), 32'(ee));
        check("mem_ready", 32'(mem_ready), 32'(er));
        check("timeout_err", 32'(timeout_err), 32'(er && m_err));
        check("mem_rdata", mem_rdata, e_rdata);
        check("paddr", paddr, e_paddr);
        check("pwdata", pwdata, e_pwdata);
        check("pwrite", 32'(pwrite), 32'(e_pwrite));
        check("pstrb", 32'(pstrb), 32'(e_pstrb));
    end

    task automatic run_dir(input string nm, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input int w, input logic [31:0] pd,
                           input logic [31:0] exp_pa, input int exp_n,
                           input logic [31:0] exp_rd, input logic exp_err);
        int n;
        bit seen;
        mem_valid = 1'b0;
        repeat (3) @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        cur_wait = w; cur_prdata = pd;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                mem_valid = 1'b0; mem_addr = 32'hffff_ffff; mem_wdata = ~wd; mem_wstrb = ~ws;
                check({nm, "_setup_psel"}, 32'(psel), 32'd1);
                check({nm, "_setup_penable"}, 32'(penable), 32'd0);
                check({nm, "_paddr"}, paddr, exp_pa);
                check({nm, "_pstrb"}, 32'(pstrb), 32'(ws));
            end
            if (n == 2) check({nm, "_access_penable"}, 32'(penable), 32'd1);
            if (mem_ready) seen = 1'b1;
        end
        check({nm, "_latency"}, 32'(n), 32'(exp_n));
        check({nm, "_rdata"}, mem_rdata, exp_rd);
        check({nm, "_terr"}, 32'(timeout_err), 32'(exp_err));
    endtask

    initial begin
        int n, r1, r2, prev, tries;
        // Reset values.
        repeat (2) @(negedge clk);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        #2 rst = 1'b0;

        run_dir("rd0", 32'h0001_0007, 32'h0, 4'b0000, 0, 32'h1234_5678, 32'h0001_0004, 3, 32'h1234_5678, 1'b0);
        run_dir("wrw", 32'h0000_0013, 32'hAABB_CCDD, 4'b0010, 3, 32'h5555_5555, 32'h0000_0010, 6, 32'h1234_5678, 1'b0);
        run_dir("tmo", 32'h0000_0020, 32'h0, 4'b0000, 9, 32'h0, 32'h0000_0020, 6, 32'hDEAD_BEEF, 1'b1);
        run_dir("last", 32'h0000_0026, 32'h0, 4'b0000, 3, 32'hCAFE_F00D, 32'h0000_0024, 6, 32'hCAFE_F00D, 1'b0);
        run_dir("wtmo", 32'h0000_0030, 32'h0102_0304, 4'b1111, 9, 32'h0, 32'h0000_0030, 6, 32'hDEAD_BEEF, 1'b1);

        // Back-to-back with mem_valid held high.
        mem_valid = 1'b0;
        repeat (3) @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'b0000;
        cur_wait = 0; cur_prdata = 32'h1111_1111;
        n = 0; r1 = 0; r2 = 0;
        while (n < 20 && r2 == 0) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                mem_addr = 32'h0000_0204; mem_wdata = 32'h2222_2222; mem_wstrb = 4'b1111;
                cur_wait = 0; cur_prdata = 32'h0;
            end
            if (n == 5) begin
                check("b2b_setup_psel", 32'(psel), 32'd1);
                check("b2b_setup_penable", 32'(penable), 32'd0);
                check("b2b_paddr", paddr, 32'h0000_0204);
                mem_valid = 1'b0;
            end
            if (mem_ready) begin
                if (r1 == 0) begin
                    r1 = n;
                    check("b2b_rdata", mem_rdata, 32'h1111_1111);
                end else r2 = n;
            end
        end
        check("b2b_first_ready", 32'(r1), 32'd3);
        check("b2b_second_ready", 32'(r2), 32'd7);

        // Random traffic; inputs change right after acceptance to prove they are ignored.
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            mem_valid  = 1'b1;
            mem_addr   = $urandom;
            mem_wdata  = $urandom;
            mem_wstrb  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cur_wait   = $urandom_range(0, 5);
            cur_prdata = $urandom;
            prev = n_acc; tries = 0;
            while (n_acc == prev && tries < 30) begin
                @(posedge clk); #1; tries++;
            end
            if (n_acc == prev) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
            if ($urandom_range(0, 2) != 0) begin
                mem_valid = 1'b0; mem_addr = $urandom; mem_wstrb = 4'($urandom);
                repeat ($urandom_range(0, 6)) @(negedge clk);
            end
        end

        // Reset during an ACCESS wait state.
        mem_valid = 1'b0;
        repeat (10) @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0050; mem_wstrb = 4'b0000; cur_wait = 9;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", 32'(penable), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_psel", 32'(psel), 32'd0);
        check("rst_mid_penable", 32'(penable), 32'd0);
        check("rst_mid_paddr", paddr, 32'd0);
        check("rst_mid_rdata", mem_rdata, 32'd0);
        check("rst_mid_ready", 32'(mem_ready), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        run_dir("post_rst", 32'h0000_0044, 32'h0, 4'b0000, 1, 32'h0BAD_F00D, 32'h0000_0044, 4, 32'h0BAD_F00D, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
